// File: rtl/obi_mem_responder.sv
// OBI slave endpoint: word-addressed memory with byte-enable writes, answering every
// accepted request in order after a fixed LATENCY through a {valid, err, rdata} shift register.
module obi_mem_responder #(
    parameter int          NUM_WORDS = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ERR_RDATA = 32'hBADC_AB1E
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [69:0] slave_req_i,
    output logic [33:0] slave_resp_o,
    input  logic        gnt_stall_i,
    output logic        err_o
);

    localparam int          AW   = $clog2(NUM_WORDS);
    localparam logic [31:0] SPAN = 32'(NUM_WORDS * 4);

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } rsp_stage_t;

    obi_req_t   req;
    obi_resp_t  resp;
    logic       gnt;
    logic [31:0] off;
    logic       in_range;
    logic [AW-1:0] word_idx;

    logic [31:0] mem [NUM_WORDS];
    rsp_stage_t  pipe [LATENCY];
    rsp_stage_t  head;
    rsp_stage_t  tail;

    assign req = slave_req_i;

    // gnt doubles as the accept strobe: it already implies req.
    assign gnt      = req.req & ~gnt_stall_i & ~rst_i;
    assign off      = req.addr - BASE_ADDR;
    assign in_range = off < SPAN;
    assign word_idx = off[2 +: AW];

    // NOTE: the memory array has no reset; its contents deliberately survive rst_i.
    always_ff @(posedge clk_i) begin
        if (gnt && req.we && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (req.be[k]) begin
                    mem[word_idx][8*k +: 8] <= req.wdata[8*k +: 8];
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        head       = '0;
        head.valid = gnt;
        head.err   = gnt & ~in_range;
        if (gnt && !req.we) begin
            head.rdata = in_range ? mem[word_idx] : ERR_RDATA;
        end
    end

    // NOTE: state registers use non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= head;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Outputs are also masked by rst_i so a response already at the tail is dropped.
    always_comb begin
        tail = pipe[LATENCY-1];
        resp = '0;
        resp.gnt = gnt;
        if (tail.valid && !rst_i) begin
            resp.rvalid = 1'b1;
            resp.rdata  = tail.rdata;
        end
        err_o        = tail.valid & tail.err & ~rst_i;
        slave_resp_o = resp;
    end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: three instances (LATENCY 1/4/3, different bases) share one
// offset-based stimulus; a history-of-accepts model predicts every response cycle by cycle.
module tb_obi_mem_responder;

    localparam logic [31:0] ERR    = 32'hBADC_AB1E;
    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'h0001_0000;
    localparam logic [31:0] BASE_C = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] off;
    logic [31:0] wdata;
    logic        stall;

    logic [33:0] resp_a, resp_b, resp_c;
    logic        err_a, err_b, err_c;

    always #5 clk = ~clk;

    obi_mem_responder #(.NUM_WORDS(1024), .LATENCY(1), .BASE_ADDR(BASE_A)) u_a (
        .clk_i(clk), .rst_i(rst), .slave_req_i({req, we, be, off + BASE_A, wdata}),
        .slave_resp_o(resp_a), .gnt_stall_i(stall), .err_o(err_a));

    obi_mem_responder #(.NUM_WORDS(1024), .LATENCY(4), .BASE_ADDR(BASE_B)) u_b (
        .clk_i(clk), .rst_i(rst), .slave_req_i({req, we, be, off + BASE_B, wdata}),
        .slave_resp_o(resp_b), .gnt_stall_i(stall), .err_o(err_b));

    obi_mem_responder #(.NUM_WORDS(1024), .LATENCY(3), .BASE_ADDR(BASE_C)) u_c (
        .clk_i(clk), .rst_i(rst), .slave_req_i({req, we, be, off + BASE_C, wdata}),
        .slave_resp_o(resp_c), .gnt_stall_i(stall), .err_o(err_c));

    // Model: what was accepted at each edge and what it must answer.
    typedef struct {
        bit          valid;
        bit          err;
        logic [31:0] rdata;
    } rec_t;

    rec_t        hist [0:4095];
    logic [31:0] mem_m [0:1023];
    int          edge_n     = 0;
    int          flush_edge = 0;
    int          checks     = 0;
    int          failures   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic        in_r;
        logic [9:0]  idx;
        logic [31:0] rd;
        edge_n++;
        hist[edge_n] = '{valid: 1'b0, err: 1'b0, rdata: 32'h0};
        if (rst) begin
            flush_edge = edge_n;
        end else if (req && !stall) begin
            in_r = off < 32'd4096;
            idx  = off[11:2];
            rd   = we ? 32'h0 : (in_r ? mem_m[idx] : ERR);
            hist[edge_n] = '{valid: 1'b1, err: !in_r, rdata: rd};
            if (we && in_r) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) mem_m[idx][8*k +: 8] = wdata[8*k +: 8];
                end
            end
        end
    endtask

    task automatic cmp(input string tag, input logic [33:0] r, input logic e, input int lat);
        rec_t x;
        int   a;
        x = '{valid: 1'b0, err: 1'b0, rdata: 32'h0};
        a = edge_n - lat + 1;
        if (!rst && a >= 1 && a > flush_edge) x = hist[a];
        check($sformatf("%s_gnt", tag),    64'(r[33]),   64'(req & ~stall & ~rst));
        check($sformatf("%s_rvalid", tag), 64'(r[32]),   64'(x.valid));
        check($sformatf("%s_rdata", tag),  64'(r[31:0]), 64'(x.rdata));
        check($sformatf("%s_err", tag),    64'(e),       64'(x.valid & x.err));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp("lat1", resp_a, err_a, 1);
            cmp("lat4", resp_b, err_b, 4);
            cmp("lat3", resp_c, err_c, 3);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        req = 1'b0; we = 1'b0; be = 4'h0; off = 32'h0; wdata = 32'h0; stall = 1'b0;
    endtask

    task automatic drive(input logic w, input logic [31:0] o, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = w; off = o; wdata = d; be = b;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        check("reset_resp_lat1", 64'(resp_a), 64'h0);
        check("reset_err_lat1",  64'(err_a),  64'h0);
        tick();
        rst = 1'b0;

        // Write then immediate read of the same word.
        drive(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        #1 check("wr_gnt_lat1", 64'(resp_a[33]), 64'h1);
        tick();
        check("wr_resp_lat1", 64'(resp_a[32:0]), {31'h0, 1'b1, 32'h0});
        drive(1'b0, 32'h10, 32'h0, 4'h0);
        #1 check("rd_gnt_lat1", 64'(resp_a[33]), 64'h1);
        tick();
        check("rd_resp_lat1", 64'(resp_a[32:0]), {31'h0, 1'b1, 32'hDEAD_BEEF});
        idle();
        tick();

        // Byte-enable merge, then a be=0 no-op write.
        drive(1'b1, 32'h20, 32'h1122_3344, 4'hF);    tick();
        drive(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101); tick();
        drive(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000); tick();
        drive(1'b0, 32'h20, 32'h0, 4'h0);            tick();
        check("be_merge_lat1", 64'(resp_a[31:0]), 64'h11BB_33DD);
        idle();
        tick();

        // Preload words 0..7, drain, then 8 back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(4 * i), 32'(i), 4'hF);
            tick();
        end
        idle();
        repeat (4) tick();
        for (int j = 0; j < 8; j++) begin
            drive(1'b0, 32'(4 * j), 32'h0, 4'h0);
            tick();
            if (j >= 3) check($sformatf("b2b_lat4_%0d", j - 3), 64'(resp_b[32:0]), {31'h0, 1'b1, 32'(j - 3)});
            else        check($sformatf("b2b_lat4_quiet_%0d", j), 64'(resp_b[32]), 64'h0);
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k < 3) check($sformatf("b2b_lat4_%0d", 5 + k), 64'(resp_b[32:0]), {31'h0, 1'b1, 32'(5 + k)});
            else       check("b2b_lat4_done", 64'(resp_b[32]), 64'h0);
        end

        // Out-of-range read and write; edge words must stay intact.
        drive(1'b1, 32'h0,   32'hA0A0_A0A0, 4'hF); tick();
        drive(1'b1, 32'hFFC, 32'h5A5A_5A5A, 4'hF); tick();
        drive(1'b0, 32'h1000, 32'h0, 4'h0);
        #1 check("oor_gnt_lat1", 64'(resp_a[33]), 64'h1);
        tick();
        check("oor_rd_lat1", {31'h0, err_a, resp_a[31:0]}, {31'h0, 1'b1, ERR});
        drive(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF);
        tick();
        check("oor_wr_lat1", {31'h0, err_a, resp_a[32:0]}, {31'h0, 1'b1, 1'b1, 32'h0});
        drive(1'b0, 32'h0, 32'h0, 4'h0); tick();
        check("oor_word0_lat1", 64'(resp_a[31:0]), 64'hA0A0_A0A0);
        drive(1'b0, 32'hFFC, 32'h0, 4'h0); tick();
        check("oor_word1023_lat1", 64'(resp_a[31:0]), 64'h5A5A_5A5A);
        idle();
        repeat (4) tick();

        // Wait-state injection: three stalled cycles, accepted on the fourth.
        stall = 1'b1;
        drive(1'b0, 32'h20, 32'h0, 4'h0);
        for (int s = 0; s < 3; s++) begin
            #1 check($sformatf("stall_gnt_%0d", s), 64'(resp_a[33]), 64'h0);
            tick();
        end
        stall = 1'b0;
        #1 check("stall_release_gnt", 64'(resp_a[33]), 64'h1);
        tick();
        check("stall_resp_lat1", 64'(resp_a[32:0]), {31'h0, 1'b1, 32'h11BB_33DD});
        idle();
        repeat (5) tick();

        // Reset with three reads in flight: none of them may ever respond.
        drive(1'b0, 32'h20, 32'h0, 4'h0); tick();
        drive(1'b0, 32'h04, 32'h0, 4'h0); tick();
        drive(1'b0, 32'h08, 32'h0, 4'h0); tick();
        idle();
        rst = 1'b1;
        #1 check("rst_mask_lat3", 64'(resp_c[32]), 64'h0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rst_drop_lat3_%0d", k), 64'(resp_c[32]), 64'h0);
            tick();
        end
        drive(1'b0, 32'h20, 32'h0, 4'h0); tick();
        idle();
        tick();
        check("post_rst_early_lat3", 64'(resp_c[32]), 64'h0);
        tick();
        check("post_rst_resp_lat3", 64'(resp_c[32:0]), {31'h0, 1'b1, 32'h11BB_33DD});
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
